reg_file_rot: RTL

- Next-generation RC register file for the CGRA datapath.
- Parametrised in depth, width and number of write and read ports.
- Adds a rotating-register window: the low ROT_DEPTH logical registers are renamed by a base pointer that advances once per software-pipelined loop iteration.
- Adds same-cycle write-to-read bypass, per-entry written flags and a synchronous clear; sits between RC ALU outputs and the operand muxes.

---
 rtl/cgra_pkg.sv | 11 +
 rtl/rf_rot_map.sv | 37 +++
 rtl/reg_file_rot.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cgra_pkg.sv
// Shared CGRA datapath defaults. Per-instance widths and types are derived
// locally from each module's parameters.
package cgra_pkg;

  localparam int RF_DEPTH     = 8;
  localparam int RF_WIDTH     = 32;
  localparam int RF_N_WR      = 2;
  localparam int RF_N_RD      = 2;
  localparam int RF_ROT_DEPTH = 4;

endpackage

// File: rtl/rf_rot_map.sv
// Logical-to-physical register mapper for the rotating window.
// The low ROT_DEPTH registers are renamed by base; every other register maps to itself.
module rf_rot_map
  import cgra_pkg::*;
#(
  parameter int REGFILE_DEPTH = RF_DEPTH,
  parameter int ROT_DEPTH     = RF_ROT_DEPTH,
  parameter int REGFILE_NSEL  = $clog2(REGFILE_DEPTH)
) (
  input  logic [REGFILE_NSEL-1:0] lsel_i,
  input  logic [REGFILE_NSEL-1:0] base_i,
  output logic [REGFILE_NSEL-1:0] psel_o,
  output logic                    valid_o
);

  // One spare bit, so that ROT_DEPTH == REGFILE_DEPTH == 2**NSEL still compares correctly.
  localparam logic [REGFILE_NSEL:0] ROT_W   = (REGFILE_NSEL+1)'(ROT_DEPTH);
  localparam logic [REGFILE_NSEL:0] DEPTH_W = (REGFILE_NSEL+1)'(REGFILE_DEPTH);

  logic [REGFILE_NSEL:0] sum;
  logic [REGFILE_NSEL:0] lsel_ext;

  always_comb begin
    lsel_ext = {1'b0, lsel_i};
    sum      = lsel_ext + {1'b0, base_i};
    // base < ROT_DEPTH, so one conditional subtract completes the modulo.
    if (sum >= ROT_W) begin
      sum = sum - ROT_W;
    end
    psel_o = lsel_i;
    if ((ROT_DEPTH > 1) && (lsel_ext < ROT_W)) begin
      psel_o = sum[REGFILE_NSEL-1:0];
    end
    valid_o = (lsel_ext < DEPTH_W);
  end

endmodule

// File: rtl/reg_file_rot.sv
// Multi-port RC register file with a rotating-register window, per-entry
// written flags, synchronous clear and an optional same-cycle write bypass.
module reg_file_rot
  import cgra_pkg::*;
#(
  parameter int REGFILE_DEPTH = RF_DEPTH,
  parameter int REGFILE_NSEL  = $clog2(REGFILE_DEPTH),
  parameter int REGFILE_WIDTH = RF_WIDTH,
  parameter int N_WR          = RF_N_WR,
  parameter int N_RD          = RF_N_RD,
  parameter int ROT_DEPTH     = RF_ROT_DEPTH,
  parameter int BYPASS        = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            clr_i,
  input  logic                            ce_i,
  input  logic [N_WR-1:0]                 we_i,
  input  logic [N_WR*REGFILE_NSEL-1:0]    wsel_i,
  input  logic [N_WR*REGFILE_WIDTH-1:0]   wdata_i,
  input  logic                            rot_i,
  input  logic [N_RD*REGFILE_NSEL-1:0]    rsel_i,
  output logic [N_RD*REGFILE_WIDTH-1:0]   rdata_o,
  output logic [REGFILE_DEPTH-1:0]        written_o,
  output logic [REGFILE_NSEL-1:0]         rot_base_o
);

  localparam int NSEL = REGFILE_NSEL;
  localparam int W    = REGFILE_WIDTH;
  localparam logic [NSEL-1:0] ROT_LAST = NSEL'((ROT_DEPTH > 1) ? (ROT_DEPTH - 1) : 0);

  typedef logic [W-1:0]    word_t;
  typedef logic [NSEL-1:0] sel_t;

  word_t                    mem_q [REGFILE_DEPTH];
  word_t                    mem_d [REGFILE_DEPTH];
  logic [REGFILE_DEPTH-1:0] written_q, written_d;
  sel_t                     base_q, base_d;

  sel_t      wphys  [N_WR];
  logic      wvalid [N_WR];
  sel_t      rphys  [N_RD];
  logic      rvalid [N_RD];
  word_t     rd_data[N_RD];
  logic      wr_live;

  assign wr_live = ce_i & ~clr_i;

  for (genvar gi = 0; gi < N_WR; gi++) begin : g_wmap
    rf_rot_map #(
      .REGFILE_DEPTH(REGFILE_DEPTH),
      .ROT_DEPTH    (ROT_DEPTH),
      .REGFILE_NSEL (NSEL)
    ) u_map (
      .lsel_i (wsel_i[gi*NSEL +: NSEL]),
      .base_i (base_q),
      .psel_o (wphys[gi]),
      .valid_o(wvalid[gi])
    );
  end

  for (genvar gi = 0; gi < N_RD; gi++) begin : g_rmap
    rf_rot_map #(
      .REGFILE_DEPTH(REGFILE_DEPTH),
      .ROT_DEPTH    (ROT_DEPTH),
      .REGFILE_NSEL (NSEL)
    ) u_map (
      .lsel_i (rsel_i[gi*NSEL +: NSEL]),
      .base_i (base_q),
      .psel_o (rphys[gi]),
      .valid_o(rvalid[gi])
    );
  end

  always_comb begin
    mem_d     = mem_q;
    written_d = written_q;
    base_d    = base_q;
    if (ce_i) begin
      if (clr_i) begin
        for (int i = 0; i < REGFILE_DEPTH; i++) begin
          mem_d[i] = '0;
        end
        written_d = '0;
        base_d    = '0;
      end else begin
        // Ascending port order lets the highest-index port win a collision.
        for (int p = 0; p < N_WR; p++) begin
          if (we_i[p] && wvalid[p]) begin
            mem_d[wphys[p]]     = wdata_i[p*W +: W];
            written_d[wphys[p]] = 1'b1;
          end
        end
        if (rot_i && (ROT_DEPTH > 1)) begin
          base_d = (base_q == ROT_LAST) ? '0 : base_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < REGFILE_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      written_q <= '0;
      base_q    <= '0;
    end else begin
      for (int i = 0; i < REGFILE_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      written_q <= written_d;
      base_q    <= base_d;
    end
  end

  for (genvar gi = 0; gi < N_RD; gi++) begin : g_read
    always_comb begin
      rd_data[gi] = '0;
      if (rvalid[gi]) begin
        rd_data[gi] = mem_q[rphys[gi]];
      end
      // Same priority as the write path, so the bypass shows the value that will land.
      if (BYPASS != 0) begin
        for (int p = 0; p < N_WR; p++) begin
          if (wr_live && we_i[p] && wvalid[p] && rvalid[gi] && (wphys[p] == rphys[gi])) begin
            rd_data[gi] = wdata_i[p*W +: W];
          end
        end
      end
    end
    assign rdata_o[gi*W +: W] = rd_data[gi];
  end

  assign written_o  = written_q;
  assign rot_base_o = base_q;

endmodule
